// File: rtl/fec_burst_scheduler_if.sv
// Serial source stream in and FEC encoder stream out of the burst scheduler.
// master is the scheduler side; slave is the randomizer/MAC plus FEC encoder side.
interface fec_burst_scheduler_if;
   logic src_valid;
   logic src_data;
   logic src_last;
   logic src_ready;
   logic fec_ready;
   logic fec_valid;
   logic fec_data;

   modport master (
      input  src_valid, src_data, src_last, fec_ready,
      output src_ready, fec_valid, fec_data
   );

   modport slave (
      output src_valid, src_data, src_last, fec_ready,
      input  src_ready, fec_valid, fec_data
   );
endinterface

// File: rtl/fec_burst_scheduler.sv
// Packs the serial payload into gap-free BLOCK_BITS FEC blocks, zero-pads early-terminated
// bursts, inserts an idle gap after each burst and reports progress and errors.
module fec_burst_scheduler #(
   parameter int unsigned BLOCK_BITS = 96,
   parameter int unsigned GAP_CYCLES = 4,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                      clk_50MHz,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [CNT_W-1:0]          cfg_blocks,
   fec_burst_scheduler_if.master     bus,
   output logic                      busy,
   output logic [CNT_W-1:0]          block_count,
   output logic                      burst_done,
   input  logic                      err_clr,
   output logic [1:0]                err_status
);

   localparam int unsigned BitW = $clog2(BLOCK_BITS);
   localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
   localparam logic [BitW-1:0]  LastBit = BitW'(BLOCK_BITS - 1);
   localparam logic [GapW-1:0]  GapEnd  = GapW'(GAP_CYCLES);
   localparam logic [CNT_W-1:0] CntMax  = '1;

   typedef enum logic [1:0] {StIdle, StStream, StPad, StGap} state_e;

   state_e           state_q, state_d;
   logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
   logic             fec_valid_q, fec_valid_d;
   logic             fec_data_q, fec_data_d;
   logic             burst_done_q, burst_done_d;
   logic [1:0]       err_q, err_d;

   logic start_acc, slot_state, abort, slot, last_bit, last_acc, blk_last;

   always_comb begin
      start_acc  = (state_q == StIdle) && start && bus.fec_ready;
      slot_state = (state_q == StStream) || (state_q == StPad);
      abort      = slot_state && !bus.fec_ready;
      slot       = slot_state && bus.fec_ready;
      last_bit   = (bit_cnt_q == LastBit);
      last_acc   = (state_q == StStream) && bus.src_valid && bus.src_last;
      blk_last   = (({1'b0, blk_cnt_q} + (CNT_W + 1)'(1)) == {1'b0, n_q});
   end

   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start_acc && (cfg_blocks != '0)) state_d = StStream;
         end
         StStream: begin
            if (abort) begin
               state_d = StIdle;
            end else if (last_bit) begin
               if (last_acc || blk_last) state_d = StGap;
            end else if (last_acc) begin
               state_d = StPad;
            end
         end
         StPad: begin
            if (abort) begin
               state_d = StIdle;
            end else if (last_bit) begin
               state_d = StGap;
            end
         end
         StGap: begin
            // One extra GAP cycle covers the registered output of the final slot.
            if (gap_cnt_q == GapEnd) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bit_cnt_d    = bit_cnt_q;
      blk_cnt_d    = blk_cnt_q;
      n_d          = n_q;
      gap_cnt_d    = '0;
      fec_valid_d  = 1'b0;
      fec_data_d   = 1'b0;
      burst_done_d = 1'b0;

      if (start_acc) begin
         n_d          = cfg_blocks;
         blk_cnt_d    = '0;
         bit_cnt_d    = '0;
         burst_done_d = (cfg_blocks == '0);
      end

      if (slot) begin
         fec_valid_d = 1'b1;
         fec_data_d  = (state_q == StStream) && bus.src_valid && bus.src_data;
         bit_cnt_d   = last_bit ? '0 : bit_cnt_q + BitW'(1);
         if (last_bit && (blk_cnt_q != CntMax)) blk_cnt_d = blk_cnt_q + CNT_W'(1);
      end

      if (state_q == StGap) begin
         gap_cnt_d    = gap_cnt_q + GapW'(1);
         burst_done_d = (gap_cnt_q == GapEnd);
      end

      // A fresh error event wins over a simultaneous clear.
      err_d = (err_clr ? 2'b00 : err_q) |
              {abort, (state_q == StStream) && bus.fec_ready && !bus.src_valid};
   end

   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_q    <= '0;
         blk_cnt_q    <= '0;
         n_q          <= '0;
         gap_cnt_q    <= '0;
         fec_valid_q  <= 1'b0;
         fec_data_q   <= 1'b0;
         burst_done_q <= 1'b0;
         err_q        <= 2'b00;
      end else begin
         bit_cnt_q    <= bit_cnt_d;
         blk_cnt_q    <= blk_cnt_d;
         n_q          <= n_d;
         gap_cnt_q    <= gap_cnt_d;
         fec_valid_q  <= fec_valid_d;
         fec_data_q   <= fec_data_d;
         burst_done_q <= burst_done_d;
         err_q        <= err_d;
      end
   end

   assign bus.src_ready = (state_q == StStream);
   assign bus.fec_valid = fec_valid_q;
   assign bus.fec_data  = fec_data_q;
   assign busy          = (state_q != StIdle);
   assign block_count   = blk_cnt_q;
   assign burst_done    = burst_done_q;
   assign err_status    = err_q;

endmodule
